// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1331 pixel streamer: FSM states, window
// command bytes, frame geometry and RGB565 colours used by the pixel generators.
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    FETCH,
    PIX_HI,
    PIX_LO,
    GAP
  } state_e;

  localparam int unsigned WIDTH      = 96;
  localparam int unsigned HEIGHT     = 64;
  localparam int unsigned NUM_PIXELS = WIDTH * HEIGHT;

  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;
  localparam logic [7:0] COL_END     = 8'h5F;
  localparam logic [7:0] ROW_END     = 8'h3F;

  localparam int unsigned NUM_CMD_BYTES = 6;

  localparam logic [15:0] COLOR_BLACK = 16'h0000;
  localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
  localparam logic [15:0] COLOR_RED   = 16'hF800;
  localparam logic [15:0] COLOR_GREEN = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE  = 16'h001F;

  // Address-window prefix: full column range, then full row range.
  function automatic logic [7:0] window_cmd(input logic [2:0] idx,
                                            input logic [7:0] col_end,
                                            input logic [7:0] row_end);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CMD_SET_COL;
      3'd1:    b = 8'h00;
      3'd2:    b = col_end;
      3'd3:    b = CMD_SET_ROW;
      3'd4:    b = 8'h00;
      default: b = row_end;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/oled_pixel_streamer_spi.sv
// SPI mode-3 byte shifter: MSB first, CLK_DIV clk cycles per SCLK half-period,
// accepts a new byte on the done cycle so bytes run back-to-back.
module spi_byte_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       sclk,
  output logic       sdin,
  output logic       busy,
  output logic       done
);

  localparam int unsigned   DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             sclk_q, sclk_d;
  logic             sdin_q, sdin_d;
  logic             busy_q, busy_d;
  logic             half_end;

  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    sdin_d  = sdin_q;
    busy_d  = busy_q;

    half_end = (div_q == DIV_LAST);
    done     = busy_q && sclk_q && half_end && (bit_q == 3'd7);

    if (busy_q) begin
      if (half_end) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else if (bit_q != 3'd7) begin
          sclk_d  = 1'b0;
          bit_d   = bit_q + 3'd1;
          sdin_d  = shift_q[6];
          shift_d = {shift_q[6:0], 1'b0};
        end else begin
          busy_d = 1'b0;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    // A start on the done cycle overrides the return to idle.
    if (start) begin
      busy_d  = 1'b1;
      sclk_d  = 1'b0;
      sdin_d  = byte_in[7];
      shift_d = byte_in;
      bit_d   = '0;
      div_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b1;
      sdin_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      sdin_q  <= sdin_d;
      busy_q  <= busy_d;
    end
  end

  assign sclk = sclk_q;
  assign sdin = sdin_q;
  assign busy = busy_q;

endmodule

// File: rtl/oled_pixel_streamer.sv
// Scans the frame through pixel_index, captures pixel_data after PIXEL_LAT cycles
// and streams window commands plus RGB565 pixels to the SSD1331 over SPI.
module oled_pixel_streamer #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned PIXEL_LAT = 2,
  parameter int unsigned FRAME_GAP = 16,
  parameter int unsigned WIDTH     = oled_pkg::WIDTH,
  parameter int unsigned HEIGHT    = oled_pkg::HEIGHT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        sample_pixel,
  output logic        sending_pixels,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn
);

  import oled_pkg::*;

  localparam int unsigned WAIT_MAX = (PIXEL_LAT > FRAME_GAP) ? PIXEL_LAT : FRAME_GAP;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] LAT_LAST = WAIT_W'(PIXEL_LAT);
  localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
  localparam logic [12:0] LAST_INDEX = 13'(WIDTH * HEIGHT - 1);
  localparam logic [7:0]  COL_LAST   = 8'(WIDTH - 1);
  localparam logic [7:0]  ROW_LAST   = 8'(HEIGHT - 1);
  localparam logic [2:0]  CMD_LAST   = 3'(NUM_CMD_BYTES - 1);

  state_e            state_q, state_d;
  logic [2:0]        cmd_idx_q, cmd_idx_d;
  logic [12:0]       pix_idx_q, pix_idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        lo_byte_q, lo_byte_d;
  logic              frame_begin_q, frame_begin_d;
  logic              sample_pixel_q, sample_pixel_d;

  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_busy;
  logic       tx_done;
  logic       launch;

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .start   (tx_start),
    .byte_in (tx_byte),
    .sclk    (sclk),
    .sdin    (sdin),
    .busy    (tx_busy),
    .done    (tx_done)
  );

  always_comb begin
    state_d        = state_q;
    cmd_idx_d      = cmd_idx_q;
    pix_idx_d      = pix_idx_q;
    wait_d         = wait_q;
    lo_byte_d      = lo_byte_q;
    frame_begin_d  = 1'b0;
    sample_pixel_d = 1'b0;
    tx_start       = 1'b0;
    tx_byte        = lo_byte_q;
    launch         = 1'b0;

    unique case (state_q)
      IDLE: launch = enable;

      CMD: begin
        if (tx_done) begin
          if (cmd_idx_q == CMD_LAST) begin
            state_d        = FETCH;
            pix_idx_d      = '0;
            sample_pixel_d = 1'b1;
            wait_d         = '0;
          end else begin
            cmd_idx_d = cmd_idx_q + 3'd1;
            tx_start  = 1'b1;
            tx_byte   = window_cmd(cmd_idx_q + 3'd1, COL_LAST, ROW_LAST);
          end
        end
      end

      // The high byte goes straight from pixel_data so it is only sampled here.
      FETCH: begin
        if (wait_q == LAT_LAST && !tx_busy) begin
          lo_byte_d = pixel_data[7:0];
          tx_start  = 1'b1;
          tx_byte   = pixel_data[15:8];
          state_d   = PIX_HI;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      PIX_HI: begin
        if (tx_done) begin
          tx_start = 1'b1;
          tx_byte  = lo_byte_q;
          state_d  = PIX_LO;
        end
      end

      PIX_LO: begin
        if (tx_done) begin
          wait_d = '0;
          if (pix_idx_q < LAST_INDEX) begin
            pix_idx_d      = pix_idx_q + 13'd1;
            sample_pixel_d = 1'b1;
            state_d        = FETCH;
          end else begin
            state_d = GAP;
          end
        end
      end

      GAP: begin
        if (wait_q == GAP_LAST) begin
          if (enable) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d       = CMD;
      cmd_idx_d     = '0;
      frame_begin_d = 1'b1;
      tx_start      = 1'b1;
      tx_byte       = window_cmd(3'd0, COL_LAST, ROW_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cmd_idx_q      <= '0;
      pix_idx_q      <= '0;
      wait_q         <= '0;
      lo_byte_q      <= '0;
      frame_begin_q  <= 1'b0;
      sample_pixel_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_idx_q      <= cmd_idx_d;
      pix_idx_q      <= pix_idx_d;
      wait_q         <= wait_d;
      lo_byte_q      <= lo_byte_d;
      frame_begin_q  <= frame_begin_d;
      sample_pixel_q <= sample_pixel_d;
    end
  end

  assign pixel_index    = pix_idx_q;
  assign frame_begin    = frame_begin_q;
  assign sample_pixel   = sample_pixel_q;
  assign sending_pixels = state_q inside {FETCH, PIX_HI, PIX_LO};
  assign d_cn           = sending_pixels;
  assign cs             = (state_q == IDLE) || (state_q == GAP);

endmodule
